// File: rtl/preamble_peak_detector.sv
// Preamble peak detector: qualifies an above-threshold run, finds the window peak, marks it on a delayed stream.
// Optional macro PREAMBLE_DET_STATS_EN adds the o_det_count output counting issued marks.
module preamble_peak_detector #(
   parameter int WIDTH       = 32,
   parameter int MAG_WIDTH   = 16,
   parameter int WINDOW_LEN  = 80,
   parameter int PEAK_OFFSET = 0,
   parameter int MIN_RUN     = 1,
   parameter int HOLDOFF     = 0
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [3:0]                       i_thresh,
   input  logic [WIDTH+3*MAG_WIDTH-1:0]     i_tdata,
   input  logic                             i_tvalid,
   output logic                             i_tready,
   output logic [WIDTH-1:0]                 o_tdata,
   output logic [MAG_WIDTH-1:0]             o_tuser,
   output logic                             o_tlast,
   output logic                             o_tvalid,
   input  logic                             o_tready
`ifdef PREAMBLE_DET_STATS_EN
   ,
   output logic [15:0]                      o_det_count
`endif
);

   localparam int MW    = MAG_WIDTH + 2;
   localparam int PTR_W = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
   localparam int IDX_W = $clog2(WINDOW_LEN) + 1;
   localparam int HO_W  = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(WINDOW_LEN - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WINDOW_LEN - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [IDX_W-1:0] RUN_REQ  = IDX_W'(MIN_RUN);
   localparam logic [IDX_W-1:0] OFFSET   = IDX_W'(PEAK_OFFSET);
   localparam logic [HO_W-1:0]  HO_LAST  = HO_W'(HOLDOFF - 1);
   localparam logic [HO_W-1:0]  HO_ONE   = HO_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_QUALIFY,
      ST_SEARCH,
      ST_ALIGN,
      ST_HOLDOFF
   } state_t;

   logic [WIDTH-1:0]            in_sample;
   logic signed [MAG_WIDTH-1:0] in_pwr;
   logic signed [MAG_WIDTH-1:0] in_mag;
   logic [MAG_WIDTH-1:0]        in_phase;
   logic signed [MW-1:0]        pwr_ext;
   logic signed [MW-1:0]        mag_ext;
   logic signed [MW-1:0]        metric;
   logic                        above;
   logic                        accept;

   assign in_sample = i_tdata[WIDTH-1:0];
   assign in_pwr    = i_tdata[WIDTH +: MAG_WIDTH];
   assign in_mag    = i_tdata[WIDTH+MAG_WIDTH +: MAG_WIDTH];
   assign in_phase  = i_tdata[WIDTH+2*MAG_WIDTH +: MAG_WIDTH];

   assign pwr_ext = MW'(in_pwr);
   assign mag_ext = MW'(in_mag);
   assign metric  = mag_ext - (pwr_ext - (pwr_ext >>> i_thresh));
   assign above   = !metric[MW-1] && (metric != '0);

   // Input and output move in lock-step once the line is full, so one accept is also one output transfer.
   logic             full_q, full_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [WIDTH-1:0] line_mem [WINDOW_LEN];

   assign i_tready = !reset && (!full_q || o_tready);
   assign accept   = i_tvalid && i_tready;
   assign o_tvalid = full_q && i_tvalid;
   assign o_tdata  = line_mem[wr_ptr_q];

   always_ff @(posedge clk) begin
      if (accept) begin
         line_mem[wr_ptr_q] <= in_sample;
      end
   end

   state_t                state_q, state_d;
   logic [IDX_W-1:0]      run_q, run_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [IDX_W-1:0]      peak_idx_q, peak_idx_d;
   logic signed [MW-1:0]  peak_m_q, peak_m_d;
   logic [MAG_WIDTH-1:0]  peak_ph_q, peak_ph_d;
   logic [IDX_W-1:0]      align_q, align_d;
   logic [HO_W-1:0]       hold_q, hold_d;
   logic [IDX_W-1:0]      next_idx;
   logic [IDX_W-1:0]      next_run;
   logic [IDX_W-1:0]      target;
   logic                  mark_hit;
   logic                  greater;

   assign next_idx = idx_q + IDX_ONE;
   assign next_run = run_q + IDX_ONE;
   assign target   = peak_idx_q + OFFSET;
   assign greater  = metric > peak_m_q;
   assign mark_hit = (state_q == ST_ALIGN) && (align_q == target);
   assign o_tlast  = mark_hit;
   assign o_tuser  = mark_hit ? peak_ph_q : '0;

   always_comb begin
      state_d    = state_q;
      run_d      = run_q;
      idx_d      = idx_q;
      peak_idx_d = peak_idx_q;
      peak_m_d   = peak_m_q;
      peak_ph_d  = peak_ph_q;
      align_d    = align_q;
      hold_d     = hold_q;
      full_d     = full_q;
      wr_ptr_d   = wr_ptr_q;

      if (accept) begin
         wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
         if (wr_ptr_q == PTR_LAST) begin
            full_d = 1'b1;
         end

         case (state_q)
            ST_IDLE: begin
               if (above) begin
                  run_d      = IDX_ONE;
                  idx_d      = '0;
                  peak_idx_d = '0;
                  peak_m_d   = metric;
                  peak_ph_d  = in_phase;
                  state_d    = (MIN_RUN == 1) ? ST_SEARCH : ST_QUALIFY;
               end
            end
            // Qualifying beats already belong to the window and take part in the peak search.
            ST_QUALIFY: begin
               if (above) begin
                  run_d = next_run;
                  idx_d = next_idx;
                  if (greater) begin
                     peak_idx_d = next_idx;
                     peak_m_d   = metric;
                     peak_ph_d  = in_phase;
                  end
                  if (next_run == RUN_REQ) begin
                     if (next_idx == IDX_LAST) begin
                        state_d = ST_ALIGN;
                        align_d = '0;
                     end else begin
                        state_d = ST_SEARCH;
                     end
                  end
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_SEARCH: begin
               idx_d = next_idx;
               if (greater) begin
                  peak_idx_d = next_idx;
                  peak_m_d   = metric;
                  peak_ph_d  = in_phase;
               end
               if (next_idx == IDX_LAST) begin
                  state_d = ST_ALIGN;
                  align_d = '0;
               end
            end
            // The first accept after the window closes outputs window index 0.
            ST_ALIGN: begin
               if (mark_hit) begin
                  hold_d  = '0;
                  state_d = (HOLDOFF == 0) ? ST_IDLE : ST_HOLDOFF;
               end else begin
                  align_d = align_q + IDX_ONE;
               end
            end
            ST_HOLDOFF: begin
               if (hold_q == HO_LAST) begin
                  state_d = ST_IDLE;
               end else begin
                  hold_d = hold_q + HO_ONE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         run_q      <= '0;
         idx_q      <= '0;
         peak_idx_q <= '0;
         peak_m_q   <= '0;
         peak_ph_q  <= '0;
         align_q    <= '0;
         hold_q     <= '0;
         full_q     <= 1'b0;
         wr_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         run_q      <= run_d;
         idx_q      <= idx_d;
         peak_idx_q <= peak_idx_d;
         peak_m_q   <= peak_m_d;
         peak_ph_q  <= peak_ph_d;
         align_q    <= align_d;
         hold_q     <= hold_d;
         full_q     <= full_d;
         wr_ptr_q   <= wr_ptr_d;
      end
   end

`ifdef PREAMBLE_DET_STATS_EN
   logic [15:0] det_count_q, det_count_d;

   always_comb begin
      det_count_d = det_count_q;
      if (accept && mark_hit && (det_count_q != 16'hFFFF)) begin
         det_count_d = det_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         det_count_q <= '0;
      end else begin
         det_count_q <= det_count_d;
      end
   end

   assign o_det_count = det_count_q;
`endif

endmodule

// File: tb/tb_preamble_peak_detector.sv
// Bench for preamble_peak_detector: two parameterisations share one input stream and are checked
// against a window-level reference model of where marks fall.
module tb_preamble_peak_detector;

   localparam int W     = 8;
   localparam int MAXN  = 400;
   localparam int MINR_B = 3;
   localparam int HOLD_B = 16;
   localparam int OFF_B  = 3;

   logic        clk;
   logic        reset;
   logic [3:0]  i_thresh;
   logic [79:0] i_tdata;
   logic        i_tvalid;
   logic        o_tready;

   logic        i_tready_a, o_tlast_a, o_tvalid_a;
   logic [31:0] o_tdata_a;
   logic [15:0] o_tuser_a;
   logic        i_tready_b, o_tlast_b, o_tvalid_b;
   logic [31:0] o_tdata_b;
   logic [15:0] o_tuser_b;
`ifdef PREAMBLE_DET_STATS_EN
   logic [15:0] det_a, det_b;
`endif

   preamble_peak_detector #(.WIDTH(32), .MAG_WIDTH(16), .WINDOW_LEN(W),
                            .PEAK_OFFSET(0), .MIN_RUN(1), .HOLDOFF(0)) dut_a (
      .clk(clk), .reset(reset), .i_thresh(i_thresh), .i_tdata(i_tdata),
      .i_tvalid(i_tvalid), .i_tready(i_tready_a), .o_tdata(o_tdata_a),
      .o_tuser(o_tuser_a), .o_tlast(o_tlast_a), .o_tvalid(o_tvalid_a),
      .o_tready(o_tready)
`ifdef PREAMBLE_DET_STATS_EN
      , .o_det_count(det_a)
`endif
   );

   preamble_peak_detector #(.WIDTH(32), .MAG_WIDTH(16), .WINDOW_LEN(W),
                            .PEAK_OFFSET(OFF_B), .MIN_RUN(MINR_B), .HOLDOFF(HOLD_B)) dut_b (
      .clk(clk), .reset(reset), .i_thresh(i_thresh), .i_tdata(i_tdata),
      .i_tvalid(i_tvalid), .i_tready(i_tready_b), .o_tdata(o_tdata_b),
      .o_tuser(o_tuser_b), .o_tlast(o_tlast_b), .o_tvalid(o_tvalid_b),
      .o_tready(o_tready)
`ifdef PREAMBLE_DET_STATS_EN
      , .o_det_count(det_b)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          vectors = 0;
   int          miscompares = 0;
   int          thresh;
   int          mag [MAXN];
   int          pwr [MAXN];
   logic [15:0] ph  [MAXN];
   logic [31:0] smp [MAXN];
   bit          exp_last [2][MAXN];
   logic [15:0] exp_user [2][MAXN];
   int          marks_a [$];
   int          marks_b [$];

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic int metric(input int b);
      int p;
      p = pwr[b];
      return mag[b] - (p - (p >>> thresh));
   endfunction

   // Reference: scan for a qualified run, take the earliest maximum of the following window,
   // then skip the beats that are consumed by alignment and holdoff.
   task automatic model_marks(input int cfg, input int n, input int minrun, input int holdoff, input int off);
      int k, best, mk, acc;
      bit ok;
      for (int b = 0; b < MAXN; b++) begin
         exp_last[cfg][b] = 1'b0;
         exp_user[cfg][b] = '0;
      end
      k = 0;
      while (k < n) begin
         if (metric(k) <= 0) begin
            k++;
            continue;
         end
         ok = 1'b1;
         for (int j = 1; j < minrun; j++) begin
            if (ok) begin
               if (k + j >= n) begin
                  ok = 1'b0;
                  k = n;
               end else if (metric(k + j) <= 0) begin
                  ok = 1'b0;
                  k = k + j;
               end
            end
         end
         if (!ok) continue;
         if (k + W - 1 >= n) break;
         best = 0;
         for (int i = 1; i < W; i++) begin
            if (metric(k + i) > metric(k + best)) best = i;
         end
         mk  = k + best + off;
         acc = mk + W;
         if (acc >= n) break;
         exp_last[cfg][mk] = 1'b1;
         exp_user[cfg][mk] = ph[k + best];
         k = acc + holdoff + 1;
      end
   endtask

   task automatic clear_stream(input int n);
      for (int b = 0; b < n; b++) begin
         mag[b] = 0;
         pwr[b] = 1000;
         ph[b]  = 16'($urandom);
         smp[b] = $urandom;
      end
   endtask

   task automatic put_preamble(input int at, input bit equal_peaks);
      int shape [8] = '{950, 960, 990, 970, 965, 955, 945, 940};
      for (int i = 0; i < 8; i++) mag[at + i] = shape[i];
      if (equal_peaks) mag[at + 5] = 990;
   endtask

   task automatic apply_reset(input bit tvalid_during);
      @(negedge clk);
      i_tvalid = tvalid_during;
      reset = 1'b1;
      #1;
      checkOutput("rst_tready_a", i_tready_a, 1'b0);
      checkOutput("rst_tready_b", i_tready_b, 1'b0);
      checkOutput("rst_tvalid_a", o_tvalid_a, 1'b0);
      checkOutput("rst_tvalid_b", o_tvalid_b, 1'b0);
      checkOutput("rst_tlast_a", o_tlast_a, 1'b0);
      checkOutput("rst_tlast_b", o_tlast_b, 1'b0);
      checkOutput("rst_tuser_a", o_tuser_a, 16'h0);
      checkOutput("rst_tuser_b", o_tuser_b, 16'h0);
`ifdef PREAMBLE_DET_STATS_EN
      checkOutput("rst_det_a", det_a, 16'h0);
      checkOutput("rst_det_b", det_b, 16'h0);
`endif
      repeat (2) @(negedge clk);
      reset = 1'b0;
      i_tvalid = 1'b0;
   endtask

   // Drives beats 0..n_stop-1 and checks every presented output beat against the model.
   task automatic applyStimulus(input int n_stop, input bit rand_hs);
      int beat = 0;
      int cycles = 0;
      int head;
      marks_a.delete();
      marks_b.delete();
      while (beat < n_stop) begin
         @(negedge clk);
         i_tvalid = rand_hs ? ($urandom_range(0, 3) != 0) : 1'b1;
         o_tready = rand_hs ? ($urandom_range(0, 2) != 0) : 1'b1;
         i_tdata  = {ph[beat], 16'(mag[beat]), 16'(pwr[beat]), smp[beat]};
         #2;
         checkOutput("tready_a", i_tready_a, (beat < W) ? 1'b1 : o_tready);
         checkOutput("tready_b", i_tready_b, (beat < W) ? 1'b1 : o_tready);
         checkOutput("tvalid_a", o_tvalid_a, (beat >= W) && i_tvalid);
         checkOutput("tvalid_b", o_tvalid_b, (beat >= W) && i_tvalid);
         if (o_tvalid_a && beat >= W) begin
            head = beat - W;
            checkOutput($sformatf("tdata_a[%0d]", head), o_tdata_a, smp[head]);
            checkOutput($sformatf("tlast_a[%0d]", head), o_tlast_a, exp_last[0][head]);
            checkOutput($sformatf("tuser_a[%0d]", head), o_tuser_a, exp_user[0][head]);
            if (o_tready && o_tlast_a) marks_a.push_back(head);
         end
         if (o_tvalid_b && beat >= W) begin
            head = beat - W;
            checkOutput($sformatf("tdata_b[%0d]", head), o_tdata_b, smp[head]);
            checkOutput($sformatf("tlast_b[%0d]", head), o_tlast_b, exp_last[1][head]);
            checkOutput($sformatf("tuser_b[%0d]", head), o_tuser_b, exp_user[1][head]);
            if (o_tready && o_tlast_b) marks_b.push_back(head);
         end
         if (i_tvalid && i_tready_a) beat++;
         cycles++;
         if (cycles > 20 * n_stop + 100) begin
            vectors++;
            miscompares++;
            $error("[TB] FAIL timeout observed beats=%0d expected beats=%0d", beat, n_stop);
            break;
         end
      end
      @(negedge clk);
      i_tvalid = 1'b0;
   endtask

   task automatic build_models(input int n);
      model_marks(0, n, 1, 0, 0);
      model_marks(1, n, MINR_B, HOLD_B, OFF_B);
   endtask

   initial begin
      reset    = 1'b1;
      i_tvalid = 1'b0;
      o_tready = 1'b1;
      i_tdata  = '0;
      thresh   = 4;
      i_thresh = 4'(thresh);
      $display("[TB] start");

      // Single preamble, free-flowing then randomly stalled.
      apply_reset(1'b0);
      clear_stream(60);
      put_preamble(20, 1'b0);
      build_models(60);
      applyStimulus(60, 1'b0);
      checkOutput("single_marks_a", marks_a.size(), 1);
      if (marks_a.size() > 0) checkOutput("single_pos_a", marks_a[0], 22);
      checkOutput("single_marks_b", marks_b.size(), 1);
      if (marks_b.size() > 0) checkOutput("single_pos_b", marks_b[0], 25);
`ifdef PREAMBLE_DET_STATS_EN
      checkOutput("det_a_1", det_a, 16'd1);
      checkOutput("det_b_1", det_b, 16'd1);
`endif
      apply_reset(1'b0);
      applyStimulus(60, 1'b1);
      checkOutput("stall_marks_a", marks_a.size(), 1);
      if (marks_a.size() > 0) checkOutput("stall_pos_a", marks_a[0], 22);

      // Isolated spike followed by a long run.
      apply_reset(1'b0);
      clear_stream(70);
      mag[10] = 1000;
      for (int b = 30; b <= 40; b++) mag[b] = int'($urandom_range(940, 1200));
      build_models(70);
      applyStimulus(70, 1'b1);
      checkOutput("minrun_marks_b", marks_b.size(), 1);
      if (marks_b.size() > 0)
         checkOutput("minrun_in_window_b", (marks_b[0] - OFF_B >= 30) && (marks_b[0] - OFF_B <= 37), 1'b1);

      // Holdoff: second preamble 12 beats after the first is dropped, the one 40 after is kept.
      apply_reset(1'b0);
      clear_stream(100);
      put_preamble(20, 1'b0);
      put_preamble(32, 1'b0);
      put_preamble(60, 1'b0);
      build_models(100);
      applyStimulus(100, 1'b1);
      checkOutput("holdoff_marks_b", marks_b.size(), 2);
      if (marks_b.size() > 1) checkOutput("holdoff_pos_b", marks_b[1], 65);
      checkOutput("holdoff_marks_a", marks_a.size(), 3);

      // Equal peaks at window indices 2 and 5: the earlier one wins.
      apply_reset(1'b0);
      clear_stream(60);
      put_preamble(20, 1'b1);
      build_models(60);
      applyStimulus(60, 1'b0);
      if (marks_b.size() > 0) checkOutput("equal_pos_b", marks_b[0], 25);
      else checkOutput("equal_marks_b", marks_b.size(), 1);
      if (marks_a.size() > 0) checkOutput("equal_pos_a", marks_a[0], 22);
      else checkOutput("equal_marks_a", marks_a.size(), 1);

      // Reset while searching aborts the window.
      apply_reset(1'b0);
      clear_stream(60);
      put_preamble(20, 1'b0);
      build_models(60);
      applyStimulus(24, 1'b0);
      i_tvalid = 1'b1;
      #1;
      checkOutput("pre_rst_tvalid_a", o_tvalid_a, 1'b1);
      apply_reset(1'b1);
      clear_stream(40);
      build_models(40);
      applyStimulus(40, 1'b0);
      checkOutput("post_rst_marks_a", marks_a.size(), 0);
      checkOutput("post_rst_marks_b", marks_b.size(), 0);

      // Fully random metric stream with random handshakes and threshold.
      apply_reset(1'b0);
      thresh   = int'($urandom_range(0, 15));
      i_thresh = 4'(thresh);
      for (int b = 0; b < 300; b++) begin
         logic [15:0] r1, r2;
         r1 = 16'($urandom);
         r2 = 16'($urandom);
         mag[b] = int'($signed(r1));
         pwr[b] = int'($signed(r2));
         ph[b]  = 16'($urandom);
         smp[b] = $urandom;
      end
      build_models(300);
      applyStimulus(300, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
